// File: rtl/usb_txn_fifo_pkg.sv
// Shared defaults and pointer helpers for usb_txn_fifo.
// Pointers are AW+1 bits wide; the extra MSB is the wrap bit.
package usb_txn_fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 64;

    // Modulo-2^(aw+1) difference a - b, zero-extended to 32 bits.
    function automatic logic [31:0] ptr_diff(input logic [31:0] a, input logic [31:0] b,
                                             input int aw);
        logic [31:0] mask;
        mask = (32'd1 << (aw + 1)) - 32'd1;
        return (a - b) & mask;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/usb_txn_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
// The read register holds its value when re is low.
module usb_txn_fifo_ram
    import usb_txn_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/usb_txn_fifo.sv
// Endpoint FIFO with packet commit/discard on the write side and optional
// commit/rewind on the read side (enabled by USB_TXN_FIFO_REWIND_EN).
module usb_txn_fifo
    import usb_txn_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic             wrreq,
    input  logic             wr_commit,
    input  logic             wr_discard,
    output logic             wrfull,
    output logic [AW:0]      wr_used,
    output logic [WIDTH-1:0] q,
    input  logic             rdreq,
    input  logic             rd_commit,
    input  logic             rd_rewind,
    output logic             rdempty,
    output logic [AW:0]      rd_avail
);

    if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_depth_chk
        $error("usb_txn_fifo: DEPTH must be a power of two and at least 2");
    end

    localparam logic [AW:0] DEPTH_P = (AW + 1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      wr_cmt;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      rd_cmt;
    logic             wr_acc;
    logic             rd_acc;
    logic             rd_hold;
    logic             rd_seen;
    logic [WIDTH-1:0] ram_q;

    // Flags come only from registered pointers.
    assign wr_used  = (AW + 1)'(ptr_diff(32'(wr_ptr), 32'(rd_cmt), AW));
    assign rd_avail = (AW + 1)'(ptr_diff(32'(wr_cmt), 32'(rd_ptr), AW));
    assign wrfull   = (wr_used == DEPTH_P);
    assign rdempty  = (rd_ptr == wr_cmt);

    assign wr_acc = wrreq && !wrfull && !wr_discard;
    assign rd_acc = rdreq && !rdempty && !rd_hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            wr_cmt <= '0;
        end else begin
            if (wr_discard) begin
                wr_ptr <= wr_cmt;
            end else if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (wr_commit && !wr_discard) begin
                wr_cmt <= wr_acc ? wr_ptr + PTR_ONE : wr_ptr;
            end
        end
    end

`ifdef USB_TXN_FIFO_REWIND_EN
    assign rd_hold = rd_rewind;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            rd_cmt <= '0;
        end else begin
            if (rd_rewind) begin
                rd_ptr <= rd_cmt;
            end else if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (rd_commit && !rd_rewind) begin
                rd_cmt <= rd_acc ? rd_ptr + PTR_ONE : rd_ptr;
            end
        end
    end
`else
    // Without rewind every accepted read releases its entry at once.
    logic unused_rd_txn;
    assign unused_rd_txn = rd_commit ^ rd_rewind;
    assign rd_hold       = 1'b0;
    assign rd_cmt        = rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
        end else if (rd_acc) begin
            rd_ptr <= rd_ptr + PTR_ONE;
        end
    end
`endif

    // The RAM output register has no reset, so q is forced to zero until
    // the first read after reset loads it.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_seen <= 1'b0;
        end else if (rd_acc) begin
            rd_seen <= 1'b1;
        end
    end

    assign q = rd_seen ? ram_q : '0;

    usb_txn_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (data),
        .re    (rd_acc),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_usb_txn_fifo.sv
// Self-checking bench for usb_txn_fifo (WIDTH=8, DEPTH=16), directed steps plus
// a randomized packet phase, compared against a queue-based packet model.
module tb_usb_txn_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
`ifdef USB_TXN_FIFO_REWIND_EN
    localparam bit REW = 1'b1;
`else
    localparam bit REW = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] data;
    logic             wrreq, wr_commit, wr_discard;
    logic             rdreq, rd_commit, rd_rewind;
    logic             wrfull, rdempty;
    logic [AW:0]      wr_used, rd_avail;
    logic [WIDTH-1:0] q;

    int total = 0;
    int bad   = 0;

    // Model: uncommitted writes, committed unread words, read-but-unreleased words.
    logic [WIDTH-1:0] wq[$];
    logic [WIDTH-1:0] cq[$];
    logic [WIDTH-1:0] rq[$];
    logic [WIDTH-1:0] q_exp;

    always #5 clk = ~clk;

    usb_txn_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .data       (data),
        .wrreq      (wrreq),
        .wr_commit  (wr_commit),
        .wr_discard (wr_discard),
        .wrfull     (wrfull),
        .wr_used    (wr_used),
        .q          (q),
        .rdreq      (rdreq),
        .rd_commit  (rd_commit),
        .rd_rewind  (rd_rewind),
        .rdempty    (rdempty),
        .rd_avail   (rd_avail)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int used_m();
        return wq.size() + cq.size() + rq.size();
    endfunction

    task automatic check_all();
        chk("rdempty",  32'(rdempty),  32'(cq.size() == 0));
        chk("wrfull",   32'(wrfull),   32'(used_m() == DEPTH));
        chk("wr_used",  32'(wr_used),  32'(used_m()));
        chk("rd_avail", 32'(rd_avail), 32'(cq.size()));
        chk("q",        32'(q),        32'(q_exp));
    endtask

    // Apply one clock edge to the model using the inputs currently driven.
    task automatic model_step();
        bit full, empty, racc;
        if (reset) begin
            wq.delete(); cq.delete(); rq.delete();
            q_exp = '0;
            return;
        end
        full  = (used_m() == DEPTH);
        empty = (cq.size() == 0);
        racc  = rdreq && !empty && !(REW && rd_rewind);
        if (racc) begin
            q_exp = cq.pop_front();
            if (REW) rq.push_back(q_exp);
        end
        if (REW && rd_rewind) begin
            for (int i = rq.size() - 1; i >= 0; i--) cq.push_front(rq[i]);
            rq.delete();
        end else if (REW && rd_commit) begin
            rq.delete();
        end
        if (wr_discard) begin
            wq.delete();
        end else begin
            if (wrreq && !full) wq.push_back(data);
            if (wr_commit) begin
                foreach (wq[i]) cq.push_back(wq[i]);
                wq.delete();
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic wc,
                        input logic wd, input logic r, input logic rc, input logic rw);
        wrreq = w; data = d; wr_commit = wc; wr_discard = wd;
        rdreq = r; rd_commit = rc; rd_rewind = rw;
        tick();
        wrreq = 0; data = '0; wr_commit = 0; wr_discard = 0;
        rdreq = 0; rd_commit = 0; rd_rewind = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdempty"},  32'(rdempty),  1);
        chk({tag, "_wrfull"},   32'(wrfull),   0);
        chk({tag, "_wr_used"},  32'(wr_used),  0);
        chk({tag, "_rd_avail"}, 32'(rd_avail), 0);
        chk({tag, "_q"},        32'(q),        0);
    endtask

    initial begin
        int pk;
        int k;
        int cyc;
        reset = 1; data = '0; wrreq = 0; wr_commit = 0; wr_discard = 0;
        rdreq = 0; rd_commit = 0; rd_rewind = 0; q_exp = '0;
        repeat (2) @(posedge clk);
        #1;
        model_step();
        chk_reset_vals("reset");
        reset = 0;

        // Uncommitted words stay invisible, then commit exposes all five.
        for (int i = 1; i <= 5; i++) step(1, 8'(i), 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("nocommit_rdempty", 32'(rdempty), 1);
        step(0, 0, 1, 0, 0, 0, 0);
        chk("commit_rd_avail", 32'(rd_avail), 5);
        for (int i = 1; i <= 5; i++) begin
            step(0, 0, 0, 0, 1, 0, 0);
            chk("pkt1_q", 32'(q), 32'(i));
        end
        step(0, 0, 0, 0, 0, 1, 0);

        // Discarded packet leaves no trace.
        for (int i = 0; i < 3; i++) step(1, 8'(8'h70 + i), 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(1, 8'hAA, 0, 0, 0, 0, 0);
        step(1, 8'hBB, 1, 0, 0, 0, 0);
        chk("discard_rd_avail", 32'(rd_avail), 2);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("discard_q0", 32'(q), 32'h0AA);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("discard_q1", 32'(q), 32'h0BB);
        step(0, 0, 0, 0, 0, 1, 0);

        // Write in the same cycle as discard is dropped; discard beats commit.
        step(1, 8'h11, 0, 0, 0, 0, 0);
        step(1, 8'h22, 1, 1, 0, 0, 0);
        step(1, 8'h33, 1, 0, 0, 0, 0);
        chk("wrdisc_rd_avail", 32'(rd_avail), 1);
        step(0, 0, 0, 0, 1, 1, 0);
        chk("wrdisc_q", 32'(q), 32'h033);

        // Fill to DEPTH, overflow write ignored, space returns only on release.
        for (int i = 0; i < 15; i++) step(1, 8'(8'h40 + i), 0, 0, 0, 0, 0);
        step(1, 8'h4F, 1, 0, 0, 0, 0);
        chk("full_wrfull", 32'(wrfull), 1);
        chk("full_wr_used", 32'(wr_used), 16);
        step(1, 8'hEE, 1, 0, 0, 0, 0);
        chk("overflow_wr_used", 32'(wr_used), 16);
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 0, 0, 1, 0, 0);
            chk("full_q", 32'(q), 32'(8'h40 + i));
        end
        chk("read_no_commit_wrfull", 32'(wrfull), REW ? 1 : 0);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("rd_commit_wrfull", 32'(wrfull), 0);
        chk("rd_commit_wr_used", 32'(wr_used), 0);

        // Rewind replays a packet when enabled; ignored otherwise.
        for (int i = 0; i < 4; i++) step(1, 8'(8'h10 + i), (i == 3), 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 1, 0, 0);
            chk("rew_q", 32'(q), 32'(8'h10 + i));
        end
        step(0, 0, 0, 0, 1, 0, 1);
        chk("rew_rd_avail", 32'(rd_avail), REW ? 4 : 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 1, 0, 0);
            chk("rew_replay_q", 32'(q), REW ? 32'(8'h10 + i) : 32'h13);
        end
        step(0, 0, 0, 0, 0, 1, 0);
        chk("rew_commit_wr_used", 32'(wr_used), 0);

        // Partial read: space is released immediately only without rewind.
        for (int i = 0; i < 4; i++) step(1, 8'(8'h20 + i), (i == 3), 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("partial_wr_used", 32'(wr_used), REW ? 4 : 2);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("partial_rew_rd_avail", 32'(rd_avail), REW ? 4 : 2);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("partial_drain_used", 32'(wr_used), 0);

        // Randomized packets across many pointer wraps.
        pk = 0; k = 0; cyc = 0;
        while (pk < 40 && cyc < 20000) begin
            logic w, c, dsc;
            bit   full_now;
            full_now = (used_m() == DEPTH);
            w   = ($urandom_range(3) != 0);
            dsc = (k > 0 && k < 6 && $urandom_range(15) == 0);
            c   = w && !full_now && !dsc && (k == 6);
            step(w, 8'($urandom), c, dsc, 1'($urandom_range(1)),
                 ($urandom_range(3) == 0), ($urandom_range(15) == 0));
            if (dsc) k = 0;
            else if (w && !full_now) begin
                if (k == 6) begin k = 0; pk++; end
                else k++;
            end
            cyc++;
        end
        chk("wrap_packets", 32'(pk), 40);

        // Reset in the middle of a packet clears everything.
        step(1, 8'h60, 0, 0, 0, 0, 0);
        step(1, 8'h61, 1, 0, 0, 0, 0);
        step(1, 8'h62, 0, 0, 1, 0, 0);
        reset = 1;
        step(1, 8'h63, 0, 0, 1, 0, 0);
        reset = 0;
        chk_reset_vals("midreset");
        step(0, 0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
